ysyx_23060025_rd_xbar: RTL and testbench
========================================

// Module: ysyx_23060025_rd_xbar
// PURPOSE
//  Read-channel crossbar between the LSU read master and two read slaves: S0 = main memory (SoC bus), S1 = CLINT.
//  Decodes the request address once and forwards it to the selected slave.
//  Routes that slave's data/response back to the master.
//  Generates a local decode-error response for unmapped addresses.
//  One outstanding transaction; sits directly upstream of the CLINT read port.
// PARAMETERS
//  ADDR_LEN     32            address width
//  DATA_LEN     32            data width
//  MEM_BASE     32'h8000_0000 S0 window low (inclusive)
//  MEM_LIMIT    32'h87ff_ffff S0 window high (inclusive)
//  CLINT_BASE   32'ha000_0048 S1 window low (inclusive), equals DEVICE_CLINT_ADDR_L
//  CLINT_LIMIT  32'ha000_004f S1 window high (inclusive), equals DEVICE_CLINT_ADDR_H
// PORTS
//  clock           in   1         single clock, rising edge
//  rstn            in   1         reset, asynchronous, active-low
//  m_ar_addr_i     in   ADDR_LEN  master read address
//  m_ar_valid_i    in   1         master address valid
//  m_ar_ready_o    out  1         xbar accepts address
//  m_r_data_o      out  DATA_LEN  read data to master
//  m_r_resp_o      out  2         read response to master (00 OKAY, 11 DECERR)
//  m_r_valid_o     out  1         read data valid to master
//  m_r_ready_i     in   1         master accepts data
//  sN_ar_addr_o    out  ADDR_LEN  N=0,1: address to slave N
//  sN_ar_valid_o   out  1         N=0,1: address valid to slave N
//  sN_ar_ready_i   in   1         N=0,1: slave N accepts address
//  sN_r_data_i     in   DATA_LEN  N=0,1: slave N read data
//  sN_r_resp_i     in   2         N=0,1: slave N response
//  sN_r_valid_i    in   1         N=0,1: slave N data valid
//  sN_r_ready_o    out  1         N=0,1: xbar accepts slave N data
// BEHAVIOUR
//  States (2b): IDLE=00, ADDR=01, DATA=10, ERR=11. Async reset -> IDLE, any cycle, mid-transaction included.
//  Reset/idle values: all *_valid_o = 0, all *_ready_o = 0 except m_ar_ready_o, m_r_data_o = 0, m_r_resp_o = 00.
//  m_ar_ready_o = (state==IDLE) && rstn.
//  IDLE:
//   - On m_ar_valid_i & m_ar_ready_o: latch addr into addr_q; latch sel_q (0=S0, 1=S1, 2=none).
//   - Next state: ADDR if mapped, ERR if unmapped.
//  Decode uses inclusive unsigned compares on the raw master address.
//  The windows never overlap; CLINT is checked first.
//  ADDR:
//   - s[sel_q]_ar_valid_o = 1 and s[sel_q]_ar_addr_o = addr_q; hold both stable until s[sel_q]_ar_ready_i.
//   - On ready -> DATA. The unselected slave sees valid=0, addr=0.
//  DATA:
//   - m_r_valid_o = s[sel_q]_r_valid_i. m_r_data_o/m_r_resp_o = slave data/resp when its valid is 1, else 0.
//   - s[sel_q]_r_ready_o = m_r_ready_i. The unselected r_ready_o is 0.
//   - Slave r_valid while r_ready is low: xbar holds in DATA; the slave must keep its data.
//   - On the m_r_valid_o & m_r_ready_i beat -> IDLE.
//  ERR: m_r_valid_o=1, m_r_resp_o=11, m_r_data_o=0; -> IDLE on m_r_ready_i. No slave is touched.
//  Latency (zero-wait slave): accept at T, slave addr handshake at T+1, data beat at T+2 at the earliest.
//   - Combinational pass-through in DATA; no extra register stage.
//   - ERR beat at T+1.
//  A new address is not accepted in the same cycle a data beat completes (ready only in IDLE).
//  Stray slave r_valid outside DATA, or from the unselected slave, is ignored: r_ready=0, no effect.
//  Slave resp is passed through unchanged; xbar never rewrites a slave response.
//  Undefined state encodings are unreachable; default branch -> IDLE.
// STRUCTURE
//  In ysyx_23060025_define.v:
//   - XBAR_SEL_MEM / XBAR_SEL_CLINT / XBAR_SEL_NONE
//   - RESP_OKAY=2'b00, RESP_DECERR=2'b11
//   - window constants, reusing DEVICE_CLINT_ADDR_L/H
//  Sub-module ysyx_23060025_addr_dec: combinational address -> 2-bit sel. Parameterised by the four window bounds.
//  FSM, addr_q and sel_q live in the top.
// TESTING
//  T1 CLINT read: request 32'ha000_0048, slave1 zero-wait returns 32'h1234 resp 00.
//     -> s1 addr handshake at T+1; master beat at T+2 with data 32'h1234, resp 00; s0 never valid.
//  T2 MEM read with slave0 ar_ready delayed 3 cycles and r_valid 2 cycles later.
//     -> s0_ar_addr_o stable throughout; a single master beat with s0 data.
//  T3 unmapped 32'h0000_1000 -> master beat at T+1: resp 11, data 0; no slave valid asserted.
//  T4 master back-pressure: m_r_ready_i low 4 cycles while s1_r_valid_i high.
//     -> s1_r_ready_o low; state stays DATA; one beat when ready rises.
//  T5 rstn pulled low in DATA, mid-beat.
//     -> same cycle, asynchronously: all valids 0, m_ar_ready_o 0.
//     -> after release: IDLE, m_ar_ready_o 1; next request completes normally.
//  T6 boundary addresses 32'ha000_004f (CLINT), 32'ha000_0050 (DECERR), 32'h87ff_ffff (MEM), 32'h8800_0000 (DECERR) -> routed as stated.

Source files
------------

// File: rtl/ysyx_23060025_rd_xbar_pkg.sv
// Shared types and constants for the LSU read-channel crossbar.
package ysyx_23060025_rd_xbar_pkg;

    // CLINT register window as seen by the rest of the SoC
    localparam logic [31:0] DEVICE_CLINT_ADDR_L = 32'ha000_0048;
    localparam logic [31:0] DEVICE_CLINT_ADDR_H = 32'ha000_004f;

    // Main memory window behind the SoC bus
    localparam logic [31:0] XBAR_MEM_BASE  = 32'h8000_0000;
    localparam logic [31:0] XBAR_MEM_LIMIT = 32'h87ff_ffff;

    // Read responses the crossbar can produce or forward
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Slave selected by the address decoder
    typedef enum logic [1:0] {
        XBAR_SEL_MEM   = 2'd0,
        XBAR_SEL_CLINT = 2'd1,
        XBAR_SEL_NONE  = 2'd2
    } xbar_sel_e;

    // Transaction state of the crossbar
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ERR  = 2'b11
    } xbar_state_e;

endpackage

// File: rtl/ysyx_23060025_rd_xbar_addr_dec.sv
// Combinational address decoder: maps a read address onto one of the slaves.
module ysyx_23060025_addr_dec
    import ysyx_23060025_rd_xbar_pkg::*;
#(
    parameter int                   ADDR_LEN    = 32,
    parameter logic [ADDR_LEN-1:0]  MEM_BASE    = XBAR_MEM_BASE,
    parameter logic [ADDR_LEN-1:0]  MEM_LIMIT   = XBAR_MEM_LIMIT,
    parameter logic [ADDR_LEN-1:0]  CLINT_BASE  = DEVICE_CLINT_ADDR_L,
    parameter logic [ADDR_LEN-1:0]  CLINT_LIMIT = DEVICE_CLINT_ADDR_H
) (
    input  logic [ADDR_LEN-1:0] i_addr,
    output xbar_sel_e           o_sel
);

    // Inclusive unsigned window checks; CLINT wins if the windows were ever to overlap
    always_comb begin
        o_sel = XBAR_SEL_NONE;
        if ((i_addr >= CLINT_BASE) && (i_addr <= CLINT_LIMIT)) begin
            o_sel = XBAR_SEL_CLINT;
        end else if ((i_addr >= MEM_BASE) && (i_addr <= MEM_LIMIT)) begin
            o_sel = XBAR_SEL_MEM;
        end
    end

endmodule

// File: rtl/ysyx_23060025_rd_xbar.sv
// Read-channel crossbar: one LSU master, main memory (S0) and CLINT (S1) slaves,
// one outstanding transaction, local DECERR for unmapped addresses.
module ysyx_23060025_rd_xbar
    import ysyx_23060025_rd_xbar_pkg::*;
#(
    parameter int                   ADDR_LEN    = 32,
    parameter int                   DATA_LEN    = 32,
    parameter logic [ADDR_LEN-1:0]  MEM_BASE    = XBAR_MEM_BASE,
    parameter logic [ADDR_LEN-1:0]  MEM_LIMIT   = XBAR_MEM_LIMIT,
    parameter logic [ADDR_LEN-1:0]  CLINT_BASE  = DEVICE_CLINT_ADDR_L,
    parameter logic [ADDR_LEN-1:0]  CLINT_LIMIT = DEVICE_CLINT_ADDR_H
) (
    input  logic                clock,
    input  logic                rstn,

    input  logic [ADDR_LEN-1:0] m_ar_addr_i,
    input  logic                m_ar_valid_i,
    output logic                m_ar_ready_o,
    output logic [DATA_LEN-1:0] m_r_data_o,
    output logic [1:0]          m_r_resp_o,
    output logic                m_r_valid_o,
    input  logic                m_r_ready_i,

    output logic [ADDR_LEN-1:0] s0_ar_addr_o,
    output logic                s0_ar_valid_o,
    input  logic                s0_ar_ready_i,
    input  logic [DATA_LEN-1:0] s0_r_data_i,
    input  logic [1:0]          s0_r_resp_i,
    input  logic                s0_r_valid_i,
    output logic                s0_r_ready_o,

    output logic [ADDR_LEN-1:0] s1_ar_addr_o,
    output logic                s1_ar_valid_o,
    input  logic                s1_ar_ready_i,
    input  logic [DATA_LEN-1:0] s1_r_data_i,
    input  logic [1:0]          s1_r_resp_i,
    input  logic                s1_r_valid_i,
    output logic                s1_r_ready_o
);

    xbar_state_e         r_state;
    xbar_state_e         w_next_state;
    logic [ADDR_LEN-1:0] r_addr_q;
    xbar_sel_e           r_sel_q;
    xbar_sel_e           w_dec_sel;
    logic                w_accept;

    ysyx_23060025_addr_dec #(
        .ADDR_LEN    (ADDR_LEN),
        .MEM_BASE    (MEM_BASE),
        .MEM_LIMIT   (MEM_LIMIT),
        .CLINT_BASE  (CLINT_BASE),
        .CLINT_LIMIT (CLINT_LIMIT)
    ) u_addr_dec (
        .i_addr (m_ar_addr_i),
        .o_sel  (w_dec_sel)
    );

    // Address is taken only in IDLE, and never while reset is asserted
    assign m_ar_ready_o = (r_state == ST_IDLE) && rstn;
    assign w_accept     = m_ar_valid_i && m_ar_ready_o;

    // State register plus the address/target captured at acceptance
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_addr_q <= '0;
            r_sel_q  <= XBAR_SEL_NONE;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr_q <= m_ar_addr_i;
                r_sel_q  <= w_dec_sel;
            end
        end
    end

    // Next-state and routing; slave data passes straight through in DATA
    always_comb begin
        w_next_state  = r_state;
        s0_ar_valid_o = 1'b0;
        s0_ar_addr_o  = '0;
        s0_r_ready_o  = 1'b0;
        s1_ar_valid_o = 1'b0;
        s1_ar_addr_o  = '0;
        s1_r_ready_o  = 1'b0;
        m_r_valid_o   = 1'b0;
        m_r_data_o    = '0;
        m_r_resp_o    = RESP_OKAY;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_dec_sel == XBAR_SEL_NONE) ? ST_ERR : ST_ADDR;
                end
            end
            ST_ADDR: begin
                case (r_sel_q)
                    XBAR_SEL_MEM: begin
                        s0_ar_valid_o = 1'b1;
                        s0_ar_addr_o  = r_addr_q;
                        if (s0_ar_ready_i) w_next_state = ST_DATA;
                    end
                    XBAR_SEL_CLINT: begin
                        s1_ar_valid_o = 1'b1;
                        s1_ar_addr_o  = r_addr_q;
                        if (s1_ar_ready_i) w_next_state = ST_DATA;
                    end
                    default: w_next_state = ST_IDLE;
                endcase
            end
            ST_DATA: begin
                case (r_sel_q)
                    XBAR_SEL_MEM: begin
                        m_r_valid_o  = s0_r_valid_i;
                        s0_r_ready_o = m_r_ready_i;
                        if (s0_r_valid_i) begin
                            m_r_data_o = s0_r_data_i;
                            m_r_resp_o = s0_r_resp_i;
                            if (m_r_ready_i) w_next_state = ST_IDLE;
                        end
                    end
                    XBAR_SEL_CLINT: begin
                        m_r_valid_o  = s1_r_valid_i;
                        s1_r_ready_o = m_r_ready_i;
                        if (s1_r_valid_i) begin
                            m_r_data_o = s1_r_data_i;
                            m_r_resp_o = s1_r_resp_i;
                            if (m_r_ready_i) w_next_state = ST_IDLE;
                        end
                    end
                    default: w_next_state = ST_IDLE;
                endcase
            end
            ST_ERR: begin
                m_r_valid_o = 1'b1;
                m_r_resp_o  = RESP_DECERR;
                if (m_r_ready_i) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060025_rd_xbar.sv
// Self-checking bench for the read crossbar: directed table, reset corner case,
// and randomized transactions checked against a window-based routing model.
module tb_ysyx_23060025_rd_xbar;

    logic        clock = 1'b0;
    logic        rstn;
    logic [31:0] m_ar_addr_i;
    logic        m_ar_valid_i;
    logic        m_ar_ready_o;
    logic [31:0] m_r_data_o;
    logic [1:0]  m_r_resp_o;
    logic        m_r_valid_o;
    logic        m_r_ready_i;
    logic [31:0] s0_ar_addr_o, s1_ar_addr_o;
    logic        s0_ar_valid_o, s1_ar_valid_o;
    logic        s0_ar_ready_i, s1_ar_ready_i;
    logic [31:0] s0_r_data_i, s1_r_data_i;
    logic [1:0]  s0_r_resp_i, s1_r_resp_i;
    logic        s0_r_valid_i, s1_r_valid_i;
    logic        s0_r_ready_o, s1_r_ready_o;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic [31:0] addr;
        int          arDelay;
        int          rDelay;
        int          mDelay;
        logic [31:0] data;
        logic [1:0]  resp;
        int          expSel;
        string       tag;
    } vec_t;

    vec_t vecs[$];

    ysyx_23060025_rd_xbar dut (
        .clock         (clock),
        .rstn          (rstn),
        .m_ar_addr_i   (m_ar_addr_i),
        .m_ar_valid_i  (m_ar_valid_i),
        .m_ar_ready_o  (m_ar_ready_o),
        .m_r_data_o    (m_r_data_o),
        .m_r_resp_o    (m_r_resp_o),
        .m_r_valid_o   (m_r_valid_o),
        .m_r_ready_i   (m_r_ready_i),
        .s0_ar_addr_o  (s0_ar_addr_o),
        .s0_ar_valid_o (s0_ar_valid_o),
        .s0_ar_ready_i (s0_ar_ready_i),
        .s0_r_data_i   (s0_r_data_i),
        .s0_r_resp_i   (s0_r_resp_i),
        .s0_r_valid_i  (s0_r_valid_i),
        .s0_r_ready_o  (s0_r_ready_o),
        .s1_ar_addr_o  (s1_ar_addr_o),
        .s1_ar_valid_o (s1_ar_valid_o),
        .s1_ar_ready_i (s1_ar_ready_i),
        .s1_r_data_i   (s1_r_data_i),
        .s1_r_resp_i   (s1_r_resp_i),
        .s1_r_valid_i  (s1_r_valid_i),
        .s1_r_ready_o  (s1_r_ready_o)
    );

    always #5 clock = ~clock;

    // Routing model: 0 = memory, 1 = CLINT, 2 = decode error
    function automatic int refRoute(input logic [31:0] a);
        if (a >= 32'ha000_0048 && a <= 32'ha000_004f) return 1;
        if (a >= 32'h8000_0000 && a <= 32'h87ff_ffff) return 0;
        return 2;
    endfunction

    function automatic logic arValidOf(input int n);
        return (n == 0) ? s0_ar_valid_o : s1_ar_valid_o;
    endfunction

    function automatic logic [31:0] arAddrOf(input int n);
        return (n == 0) ? s0_ar_addr_o : s1_ar_addr_o;
    endfunction

    function automatic logic rReadyOf(input int n);
        return (n == 0) ? s0_r_ready_o : s1_r_ready_o;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic setSlave(input int n, input logic arReady, input logic rValid,
                            input logic [31:0] data, input logic [1:0] resp);
        if (n == 0) begin
            s0_ar_ready_i = arReady; s0_r_valid_i = rValid; s0_r_data_i = data; s0_r_resp_i = resp;
        end else begin
            s1_ar_ready_i = arReady; s1_r_valid_i = rValid; s1_r_data_i = data; s1_r_resp_i = resp;
        end
    endtask

    // Random junk on every slave other than the selected one
    task automatic driveStray(input int sel);
        for (int n = 0; n < 2; n++) begin
            if (n != sel) begin
                setSlave(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)));
            end
        end
    endtask

    task automatic addVec(input logic [31:0] addr, input int arDelay, input int rDelay, input int mDelay,
                          input logic [31:0] data, input logic [1:0] resp, input int expSel, input string tag);
        vec_t v;
        v.addr = addr; v.arDelay = arDelay; v.rDelay = rDelay; v.mDelay = mDelay;
        v.data = data; v.resp = resp; v.expSel = expSel; v.tag = tag;
        vecs.push_back(v);
    endtask

    // One full transaction, checked cycle by cycle from acceptance to return to idle
    task automatic applyStimulus(input logic [31:0] addr, input int expSel, input int arDelay, input int rDelay,
                                 input int mDelay, input logic [31:0] data, input logic [1:0] resp, input string tag);
        int other;
        other = (expSel == 0) ? 1 : 0;
        m_ar_addr_i  = addr;
        m_ar_valid_i = 1'b1;
        m_r_ready_i  = 1'($urandom_range(0, 1));
        driveStray(2);
        @(negedge clock);
        checkOutput({tag, " ar_ready idle"}, 64'(m_ar_ready_o), 64'd1);
        checkOutput({tag, " r_valid idle"}, 64'(m_r_valid_o), 64'd0);
        stepCycle();
        m_ar_valid_i = 1'b0;
        m_ar_addr_i  = $urandom;

        if (expSel == 2) begin
            for (int c = 0; c <= mDelay; c++) begin
                m_r_ready_i = (c == mDelay);
                driveStray(2);
                @(negedge clock);
                checkOutput({tag, " err valid"}, 64'(m_r_valid_o), 64'd1);
                checkOutput({tag, " err resp"}, 64'(m_r_resp_o), 64'd3);
                checkOutput({tag, " err data"}, 64'(m_r_data_o), 64'd0);
                checkOutput({tag, " err no slave"}, 64'({s0_ar_valid_o, s1_ar_valid_o, s0_r_ready_o, s1_r_ready_o}), 64'd0);
                checkOutput({tag, " err ar_ready"}, 64'(m_ar_ready_o), 64'd0);
                stepCycle();
            end
        end else begin
            for (int c = 0; c <= arDelay; c++) begin
                setSlave(expSel, (c == arDelay), 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)));
                driveStray(expSel);
                m_r_ready_i = 1'($urandom_range(0, 1));
                @(negedge clock);
                checkOutput({tag, " ar_valid"}, 64'(arValidOf(expSel)), 64'd1);
                checkOutput({tag, " ar_addr"}, 64'(arAddrOf(expSel)), 64'(addr));
                checkOutput({tag, " other ar"}, {31'd0, arValidOf(other), arAddrOf(other)}, 64'd0);
                checkOutput({tag, " addr r_valid"}, 64'(m_r_valid_o), 64'd0);
                checkOutput({tag, " addr r_ready"}, 64'({s0_r_ready_o, s1_r_ready_o}), 64'd0);
                checkOutput({tag, " addr ar_ready"}, 64'(m_ar_ready_o), 64'd0);
                stepCycle();
            end
            for (int c = 0; c < rDelay; c++) begin
                setSlave(expSel, 1'($urandom_range(0, 1)), 1'b0, $urandom, 2'($urandom_range(0, 3)));
                driveStray(expSel);
                m_r_ready_i = 1'($urandom_range(0, 1));
                @(negedge clock);
                checkOutput({tag, " wait r_valid"}, 64'(m_r_valid_o), 64'd0);
                checkOutput({tag, " wait r_data"}, 64'(m_r_data_o), 64'd0);
                checkOutput({tag, " wait ar_valid"}, 64'({s0_ar_valid_o, s1_ar_valid_o}), 64'd0);
                checkOutput({tag, " wait other r_ready"}, 64'(rReadyOf(other)), 64'd0);
                stepCycle();
            end
            for (int c = 0; c <= mDelay; c++) begin
                setSlave(expSel, 1'b0, 1'b1, data, resp);
                driveStray(expSel);
                m_r_ready_i = (c == mDelay);
                @(negedge clock);
                checkOutput({tag, " beat valid"}, 64'(m_r_valid_o), 64'd1);
                checkOutput({tag, " beat data"}, 64'(m_r_data_o), 64'(data));
                checkOutput({tag, " beat resp"}, 64'(m_r_resp_o), 64'(resp));
                checkOutput({tag, " beat r_ready"}, 64'(rReadyOf(expSel)), 64'(c == mDelay));
                checkOutput({tag, " beat other r_ready"}, 64'(rReadyOf(other)), 64'd0);
                checkOutput({tag, " beat ar_ready"}, 64'(m_ar_ready_o), 64'd0);
                stepCycle();
            end
        end

        m_r_ready_i = 1'b0;
        driveStray(2);
        @(negedge clock);
        checkOutput({tag, " back idle"}, 64'(m_ar_ready_o), 64'd1);
        checkOutput({tag, " idle quiet"}, 64'({m_r_valid_o, s0_ar_valid_o, s1_ar_valid_o, s0_r_ready_o, s1_r_ready_o}), 64'd0);
        stepCycle();
    endtask

    // Asynchronous reset asserted while a CLINT beat is being presented
    task automatic checkResetMidBeat();
        m_ar_addr_i  = 32'ha000_0048;
        m_ar_valid_i = 1'b1;
        setSlave(0, 1'b0, 1'b0, 32'h0, 2'b00);
        setSlave(1, 1'b0, 1'b0, 32'h0, 2'b00);
        m_r_ready_i = 1'b0;
        stepCycle();
        m_ar_valid_i = 1'b0;
        setSlave(1, 1'b1, 1'b0, 32'h0, 2'b00);
        stepCycle();
        setSlave(1, 1'b0, 1'b1, 32'h5555_aaaa, 2'b00);
        m_r_ready_i = 1'b1;
        #1;
        checkOutput("T5 pre-reset beat", 64'(m_r_valid_o), 64'd1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("T5 async valids", 64'({m_r_valid_o, s0_ar_valid_o, s1_ar_valid_o, s0_r_ready_o, s1_r_ready_o}), 64'd0);
        checkOutput("T5 async ar_ready", 64'(m_ar_ready_o), 64'd0);
        checkOutput("T5 async data", 64'({m_r_data_o, m_r_resp_o}), 64'd0);
        stepCycle();
        checkOutput("T5 held ar_ready", 64'(m_ar_ready_o), 64'd0);
        rstn = 1'b1;
        m_r_ready_i = 1'b0;
        setSlave(1, 1'b0, 1'b0, 32'h0, 2'b00);
        @(negedge clock);
        checkOutput("T5 release ar_ready", 64'(m_ar_ready_o), 64'd1);
        checkOutput("T5 release r_valid", 64'(m_r_valid_o), 64'd0);
        stepCycle();
        applyStimulus(32'ha000_004c, 1, 0, 0, 0, 32'h0bad_f00d, 2'b00, "T5 after");
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  r;
        int          pick;

        rstn = 1'b0;
        m_ar_addr_i = '0; m_ar_valid_i = 1'b0; m_r_ready_i = 1'b0;
        setSlave(0, 1'b0, 1'b0, 32'h0, 2'b00);
        setSlave(1, 1'b0, 1'b0, 32'h0, 2'b00);

        addVec(32'ha000_0048, 0, 0, 0, 32'h0000_1234, 2'b00, 1, "T1 clint");
        addVec(32'h8000_0010, 3, 2, 0, 32'hdead_beef, 2'b00, 0, "T2 mem slow");
        addVec(32'h0000_1000, 0, 0, 0, 32'h0,         2'b00, 2, "T3 unmapped");
        addVec(32'ha000_004c, 0, 0, 4, 32'hcafe_0001, 2'b00, 1, "T4 backpress");
        addVec(32'ha000_004f, 0, 1, 0, 32'h1111_2222, 2'b10, 1, "T6 clint hi");
        addVec(32'ha000_0050, 0, 0, 0, 32'h0,         2'b00, 2, "T6 clint hi+1");
        addVec(32'h87ff_ffff, 1, 0, 1, 32'h3333_4444, 2'b01, 0, "T6 mem hi");
        addVec(32'h8800_0000, 0, 0, 0, 32'h0,         2'b00, 2, "T6 mem hi+1");
        addVec(32'h8000_0000, 0, 0, 0, 32'h5a5a_5a5a, 2'b11, 0, "T6 mem lo");
        addVec(32'ha000_0047, 0, 0, 2, 32'h0,         2'b00, 2, "T6 clint lo-1");
        addVec(32'h7fff_ffff, 0, 0, 0, 32'h0,         2'b00, 2, "T6 mem lo-1");

        #12;
        checkOutput("reset ar_ready", 64'(m_ar_ready_o), 64'd0);
        checkOutput("reset valids", 64'({m_r_valid_o, s0_ar_valid_o, s1_ar_valid_o, s0_r_ready_o, s1_r_ready_o}), 64'd0);
        checkOutput("reset data", 64'({m_r_data_o, m_r_resp_o}), 64'd0);
        @(posedge clock);
        #1;
        rstn = 1'b1;
        @(negedge clock);
        checkOutput("post-reset ar_ready", 64'(m_ar_ready_o), 64'd1);
        stepCycle();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].addr, vecs[i].expSel, vecs[i].arDelay, vecs[i].rDelay, vecs[i].mDelay,
                          vecs[i].data, vecs[i].resp, vecs[i].tag);
        end

        checkResetMidBeat();

        for (int i = 0; i < 60; i++) begin
            pick = $urandom_range(0, 3);
            case (pick)
                0:       a = 32'h8000_0000 + ($urandom & 32'h07ff_ffff);
                1:       a = 32'ha000_0048 + 32'($urandom_range(0, 7));
                2:       a = 32'ha000_0040 + 32'($urandom_range(0, 31));
                default: a = $urandom;
            endcase
            d = $urandom;
            r = 2'($urandom_range(0, 3));
            applyStimulus(a, refRoute(a), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                          d, r, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
